// File: rtl/cronometro_pkg.sv
// Shared types and default timing constants for the stopwatch control front-end.
package cronometro_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } estado_t;

    localparam int unsigned DIV_DEFAULT        = 50_000_000;
    localparam int unsigned DEB_CYCLES_DEFAULT = 500_000;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw board input.
module debounce_sync
    import cronometro_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic raw_i,
    output logic clean_o
);

    localparam int unsigned   CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          clean_q;
    logic          clean_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The clean level only moves after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = '0;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean_o = clean_q;

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch control: conditioned inputs, run/hold/limit state machine and count-tick prescaler.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int unsigned DIV        = DIV_DEFAULT,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic       clk_2,
    input  logic       reset_n,
    input  logic       btn_reset_i,
    input  logic       btn_run_i,
    input  logic       sw_dir_i,
    input  logic       at_limit_i,
    output logic       tick_o,
    output logic       clear_o,
    output logic       dir_o,
    output logic       running_o,
    output logic [1:0] state_o
);

    localparam int unsigned   PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic          rst_clean;
    logic          run_clean;
    logic          dir_clean;
    logic          run_dly_q;
    logic          run_edge;
    estado_t       state_q;
    logic [PW-1:0] presc_q;
    logic          tick_q;

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_reset (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .raw_i   (btn_reset_i),
        .clean_o (rst_clean)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .raw_i   (btn_run_i),
        .clean_o (run_clean)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .raw_i   (sw_dir_i),
        .clean_o (dir_clean)
    );

    assign run_edge = run_clean & ~run_dly_q;

    // The delayed copy always tracks, so a run edge seen during CLEAR is consumed there.
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            state_q   <= HOLD;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            run_dly_q <= 1'b0;
        end else begin
            run_dly_q <= run_clean;
            tick_q    <= 1'b0;
            if (rst_clean) begin
                state_q <= CLEAR;
                presc_q <= '0;
            end else begin
                case (state_q)
                    CLEAR: begin
                        state_q <= HOLD;
                        presc_q <= '0;
                    end
                    HOLD: begin
                        if (run_edge) state_q <= RUN;
                    end
                    RUN: begin
                        if (run_edge) begin
                            state_q <= HOLD;
                        end else if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            if (at_limit_i) state_q <= DONE;
                            else            tick_q  <= 1'b1;
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    DONE: begin
                        if (run_edge) state_q <= RUN;
                    end
                    default: state_q <= HOLD;
                endcase
            end
        end
    end

    assign tick_o    = tick_q;
    assign clear_o   = (state_q == CLEAR);
    assign running_o = (state_q == RUN);
    assign state_o   = state_q;
    assign dir_o     = dir_clean;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed and randomized checks of cronometro_ctrl against a cycle-level behavioural model.
module tb_cronometro_ctrl;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       clk_2 = 1'b0;
    logic       reset_n;
    logic       btn_reset_i;
    logic       btn_run_i;
    logic       sw_dir_i;
    logic       at_limit_i;
    logic       tick_o;
    logic       clear_o;
    logic       dir_o;
    logic       running_o;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    bit r_rst = 1'b0;
    bit r_run = 1'b0;
    bit r_dir = 1'b0;
    bit r_lim = 1'b0;

    // Model: mode uses the numbering visible on state_o; index 0=reset, 1=run, 2=dir.
    int m_mode  = 1;
    int m_phase = 0;
    bit m_tick  = 1'b0;
    bit m_prev  = 1'b0;
    bit m_clean [3];
    int m_diff  [3];
    bit m_d1    [3];
    bit m_d2    [3];

    always #5 clk_2 = ~clk_2;

    cronometro_ctrl #(
        .DIV        (DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk_2       (clk_2),
        .reset_n     (reset_n),
        .btn_reset_i (btn_reset_i),
        .btn_run_i   (btn_run_i),
        .sw_dir_i    (sw_dir_i),
        .at_limit_i  (at_limit_i),
        .tick_o      (tick_o),
        .clear_o     (clear_o),
        .dir_o       (dir_o),
        .running_o   (running_o),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge of the behavioural model; FSM sees the clean levels from before the edge.
    task automatic model_edge();
        bit raw [3];
        bit edge_seen;
        raw[0] = btn_reset_i;
        raw[1] = btn_run_i;
        raw[2] = sw_dir_i;
        if (!reset_n) begin
            m_mode  = 1;
            m_phase = 0;
            m_tick  = 1'b0;
            m_prev  = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_clean[i] = 1'b0;
                m_diff[i]  = 0;
                m_d1[i]    = 1'b0;
                m_d2[i]    = 1'b0;
            end
            return;
        end
        edge_seen = m_clean[1] && !m_prev;
        m_tick    = 1'b0;
        if (m_clean[0]) begin
            m_mode  = 0;
            m_phase = 0;
        end else if (m_mode == 0) begin
            m_mode  = 1;
            m_phase = 0;
        end else if (m_mode == 2) begin
            if (edge_seen) begin
                m_mode = 1;
            end else begin
                m_phase = (m_phase + 1) % DIV;
                if (m_phase == 0) begin
                    if (at_limit_i) m_mode = 3;
                    else            m_tick = 1'b1;
                end
            end
        end else if (edge_seen) begin
            m_mode = 2;
        end
        m_prev = m_clean[1];
        for (int i = 0; i < 3; i++) begin
            if (m_d2[i] != m_clean[i]) begin
                m_diff[i]++;
                if (m_diff[i] == DEB) begin
                    m_clean[i] = m_d2[i];
                    m_diff[i]  = 0;
                end
            end else begin
                m_diff[i] = 0;
            end
            m_d2[i] = m_d1[i];
            m_d1[i] = raw[i];
        end
    endtask

    task automatic cyc(input bit rn, input bit br, input bit bu, input bit sd, input bit al);
        reset_n     = rn;
        btn_reset_i = br;
        btn_run_i   = bu;
        sw_dir_i    = sd;
        at_limit_i  = al;
        @(posedge clk_2);
        model_edge();
        @(negedge clk_2);
        chk("state",   32'(state_o),   32'(m_mode));
        chk("tick",    32'(tick_o),    32'(m_tick));
        chk("clear",   32'(clear_o),   32'(m_mode == 0));
        chk("running", 32'(running_o), 32'(m_mode == 2));
        chk("dir",     32'(dir_o),     32'(m_clean[2]));
    endtask

    task automatic step();
        cyc(1'b1, r_rst, r_run, r_dir, r_lim);
    endtask

    initial begin
        int n;
        int cnt;
        int last;
        int h_rst;
        int h_run;
        int h_dir;
        int h_lim;

        // Reset with every raw input high
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_state",   32'(state_o),   32'd1);
        chk("rst_tick",    32'(tick_o),    32'd0);
        chk("rst_clear",   32'(clear_o),   32'd0);
        chk("rst_running", 32'(running_o), 32'd0);
        chk("rst_dir",     32'(dir_o),     32'd0);
        repeat (5) begin
            step();
            chk("rst_no_tick", 32'(tick_o), 32'd0);
        end

        // Bounce rejection then a clean press
        for (int i = 0; i < 12; i++) begin
            r_run = ((i / 2) % 2 == 0);
            step();
            chk("bounce_hold", 32'(state_o), 32'd1);
        end
        r_run = 1'b1;
        n = 0;
        do begin step(); n++; end while (running_o !== 1'b1 && n < 20);
        chk("run_latency", 32'(n), 32'd6);

        // Tick cadence from prescaler 0
        cnt  = 0;
        last = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick_o === 1'b1) begin
                if (last < 0) chk("tick_first", 32'(i), 32'd3);
                else          chk("tick_gap", 32'(i - last), 32'd4);
                cnt++;
                last = i;
            end
        end
        chk("tick_count", 32'(cnt), 32'd5);

        // Hold with prescaler at 2, then resume keeping phase
        r_run = 1'b0;
        repeat (8) step();
        n = 0;
        while (m_phase != 1 && n < 8) begin step(); n++; end
        r_run = 1'b1;
        n = 0;
        do begin step(); n++; end while (state_o !== 2'd1 && n < 20);
        chk("hold_latency", 32'(n), 32'd6);
        chk("hold_no_tick", 32'(tick_o), 32'd0);
        repeat (3) begin
            step();
            chk("hold_stays", 32'(state_o), 32'd1);
        end
        r_run = 1'b0;
        repeat (8) step();
        r_run = 1'b1;
        n = 0;
        do begin step(); n++; end while (running_o !== 1'b1 && n < 20);
        chk("resume_latency", 32'(n), 32'd6);
        n = 0;
        do begin step(); n++; end while (tick_o !== 1'b1 && n < 10);
        chk("resume_phase", 32'(n), 32'd2);

        // Limit reached in RUN, restart from DONE
        r_run = 1'b0;
        repeat (6) step();
        r_lim = 1'b1;
        n = 0;
        do begin step(); n++; end while (state_o !== 2'd3 && n < 10);
        chk("limit_state",   32'(state_o),   32'd3);
        chk("limit_tick",    32'(tick_o),    32'd0);
        chk("limit_running", 32'(running_o), 32'd0);
        chk("limit_by_wrap", 32'(n <= DIV),  32'd1);
        repeat (3) begin
            step();
            chk("done_stays", 32'(state_o), 32'd3);
        end
        r_run = 1'b1;
        n = 0;
        do begin step(); n++; end while (state_o !== 2'd2 && n < 20);
        chk("restart_latency", 32'(n), 32'd6);
        chk("restart_state", 32'(state_o), 32'd2);
        n = 0;
        do begin step(); n++; end while (state_o !== 2'd3 && n < 10);
        chk("redone_latency", 32'(n), 32'd4);

        // Reset and run pressed together: CLEAR wins, run edge discarded
        r_lim = 1'b0;
        r_run = 1'b0;
        repeat (8) step();
        r_rst = 1'b1;
        r_run = 1'b1;
        n = 0;
        do begin step(); n++; end while (clear_o !== 1'b1 && n < 20);
        chk("prio_latency", 32'(n), 32'd6);
        chk("prio_state", 32'(state_o), 32'd0);
        repeat (5) begin
            step();
            chk("prio_clear",   32'(clear_o), 32'd1);
            chk("prio_no_tick", 32'(tick_o),  32'd0);
        end
        r_rst = 1'b0;
        n = 0;
        do begin step(); n++; end while (state_o === 2'd0 && n < 20);
        chk("prio_release", 32'(state_o), 32'd1);
        chk("prio_release_latency", 32'(n), 32'd6);
        repeat (4) begin
            step();
            chk("prio_not_run", 32'(running_o), 32'd0);
        end
        r_run = 1'b0;
        repeat (8) step();
        r_run = 1'b1;
        n = 0;
        do begin step(); n++; end while (running_o !== 1'b1 && n < 20);
        n = 0;
        do begin step(); n++; end while (tick_o !== 1'b1 && n < 10);
        chk("post_clear_phase", 32'(n), 32'd4);

        // Randomized input streams with variable hold times
        h_rst = 0;
        h_run = 0;
        h_dir = 0;
        h_lim = 0;
        for (int c = 0; c < 800; c++) begin
            if (h_rst == 0) begin r_rst = ($urandom_range(0, 5) == 0); h_rst = $urandom_range(1, 8); end
            else h_rst--;
            if (h_run == 0) begin r_run = $urandom_range(0, 1) != 0; h_run = $urandom_range(1, 8); end
            else h_run--;
            if (h_dir == 0) begin r_dir = $urandom_range(0, 1) != 0; h_dir = $urandom_range(1, 8); end
            else h_dir--;
            if (h_lim == 0) begin r_lim = ($urandom_range(0, 2) == 0); h_lim = $urandom_range(1, 12); end
            else h_lim--;
            if ($urandom_range(0, 199) == 0) cyc(1'b0, r_rst, r_run, r_dir, r_lim);
            else                             step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cronometro_ctrl.md
# cronometro_ctrl

Control front-end for the 0–10 s stopwatch counter. It synchronizes and debounces the raw board switches and buttons, and runs a run/hold/limit state machine. It divides the board clock into a one-cycle count-enable tick. Its outputs (`tick_o`, `clear_o`, `dir_o`) drive the stopwatch counter directly: increment or decrement on tick, clear on `clear_o`.

## Interface
- `DIV`, 50_000_000: board-clock cycles per count tick; legal values ≥ 2.
- `DEB_CYCLES`, 500_000: consecutive stable cycles needed to accept an input change (10 ms at 50 MHz); legal values ≥ 2.
- `clk_2`  in  1  board clock; every register updates on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `btn_reset_i`  in  1  raw asynchronous clear button, active high.
- `btn_run_i`  in  1  raw asynchronous start/stop button, active high.
- `sw_dir_i`  in  1  raw asynchronous direction switch: 0 = count up, 1 = count down.
- `at_limit_i`  in  1  from the counter; high when the counter is at 10 (up) or 0 (down).
- `tick_o`  out  1  one-cycle count enable.
- `clear_o`  out  1  level; the counter clears to 0 while this is high.
- `dir_o`  out  1  debounced direction.
- `running_o`  out  1  high when `state_o` = RUN.
- `state_o`  out  2  current state: CLEAR=0, HOLD=1, RUN=2, DONE=3.

## Operation
- **Input conditioning.** Each raw input passes through a 2-flop synchronizer and then a debouncer.
  - Debouncer counter: increments each cycle the synchronized value differs from the clean level.
  - It resets to 0 on any cycle where the two are equal.
  - When the counter is at `DEB_CYCLES-1` and the values still differ, the clean level takes the synchronized value and the counter resets to 0.
- **Run edge.** Defined as clean run = 1 while its 1-cycle delayed copy = 0. It is combinational from registers.
- **Direction.** `dir_o` = clean `sw_dir_i`. It has no effect on state.
- **Prescaler.** Range 0..`DIV-1`, width `$clog2(DIV)`.
  - Increments only in RUN.
  - Holds its value in HOLD and DONE, so resuming keeps the tick phase.
  - Forced to 0 in CLEAR.
- **Transition priority:** clean reset > run edge > prescaler wrap.
  - Any state, clean reset = 1 → CLEAR.
  - CLEAR, clean reset = 0 → HOLD.
  - HOLD, run edge → RUN.
  - RUN, run edge → HOLD. The prescaler does not advance that cycle and no tick is issued.
  - RUN, prescaler = `DIV-1`:
    - Prescaler returns to 0.
    - If `at_limit_i` = 0: `tick_o` is 1 for the next cycle and the state stays RUN.
    - If `at_limit_i` = 1: state → DONE and no tick is issued.
  - DONE, run edge → RUN (restart). If the counter is still at the limit, the next wrap returns to DONE.
- **Simultaneous reset and run events:** CLEAR wins. A run edge that arrives while in CLEAR is discarded.
- **Reset (`reset_n` = 0):** takes priority over everything and applies these values:
  - State HOLD, prescaler 0.
  - Synchronizers, clean levels, delayed copies and debounce counters all 0.
  - All outputs 0.

## Timing
- `tick_o` is a registered output. `clear_o`, `running_o` and `state_o` decode the state register. `dir_o` is the clean register.
- Raw input change to clean level: 2 + `DEB_CYCLES` rising edges, provided the input stays stable.
- Raw run press to `running_o` change: `DEB_CYCLES` + 3 edges. Raw reset press to `clear_o` = 1: also `DEB_CYCLES` + 3 edges.
- Continuous RUN from prescaler 0: the first tick is high in the cycle after edge `DIV`. Period is exactly `DIV` cycles; each pulse is 1 cycle wide.
- Pulses shorter than `DEB_CYCLES` cycles produce no clean change and no state change.

## Structure
- Package `cronometro_pkg` contains:
  - `typedef enum logic [1:0] {CLEAR, HOLD, RUN, DONE} estado_t`;
  - default constants for `DIV` and `DEB_CYCLES`.
- Sub-module `debounce_sync`, parameter `DEB_CYCLES`, ports `clk_2`, `reset_n`, `raw_i`, `clean_o`. It is instantiated 3 times. The FSM, prescaler and edge detect stay in the top of the block.
- Expected RTL size is about 150–200 lines in total.

## Test plan
All scenarios use `DIV`=4 and `DEB_CYCLES`=3.
- **Reset:** hold `reset_n` = 0 for 1 edge with all inputs 1 → `state_o`=1, all outputs 0, no tick for the next 5 cycles with inputs held 0.
- **Bounce rejection:** `btn_run_i` toggles every 2 cycles for 12 cycles, then is held at 1 → `state_o` stays 1 during the toggling and becomes 2 exactly 6 edges after the last rising transition.
- **Tick cadence:** in RUN with `at_limit_i`=0 for 20 cycles → exactly 5 single-cycle `tick_o` pulses, 4 cycles apart.
- **Hold and resume:** press run while prescaler = 2 → HOLD and no tick. Press run again → RUN, with the first tick after the 2nd edge in RUN (phase kept).
- **Limit:** `at_limit_i`=1 in RUN → at the next wrap `state_o`=3, no tick, `running_o`=0. A subsequent run press → `state_o`=2.
- **Priority:** raw reset and raw run rise on the same cycle → CLEAR, `clear_o`=1 while held, prescaler 0, no tick. Release reset → `state_o`=1 and not RUN.
